mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter OPW, default 6, opcode field width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  OPW  instruction opcode from the instruction register; sampled in DECODE only.
REQ-005 mem_ready  input  1  memory handshake; high = the current read/write completes this cycle.
REQ-006 pc_write, pc_write_cond  output  1 each  PC update enables; pc_write_cond is ANDed with ALU zero outside this block.
REQ-007 i_or_d, mem_read, mem_write, ir_write  output  1 each  memory address select (0 = PC, 1 = ALUOut) and memory/IR strobes.
REQ-008 reg_dst, mem_to_reg, reg_write  output  1 each  write-back Mux2 selects and register-file write enable.
REQ-009 alu_src_a  output  1  ALU A select (0 = PC, 1 = reg A).
REQ-010 alu_src_b  output  2  ALU B Mux3 select (00 = reg B, 01 = const 4, 10 = sign-extended immediate, 11 = shifted immediate).
REQ-011 pc_src  output  2  PC Mux3 select (00 = ALU result, 01 = ALUOut, 10 = jump target).
REQ-012 alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded.
REQ-013 illegal_op  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-014 The block SHALL be a Moore FSM with states IDLE, FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB, I_EX, I_WB, BRANCH, JUMP; every output is a function of state plus mem_ready only.
REQ-015 Any output not listed for a state SHALL be 0 in that state.
REQ-016 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-017 FETCH: mem_read=1, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready; state is held while mem_ready=0, and next state is DECODE when mem_ready=1.
REQ-018 DECODE: alu_src_b=11, alu_op=00; next state by opcode: 100011/101011 -> MEM_ADR, 000000 -> R_EX, 001000 -> I_EX, 000100 -> BRANCH, 000010 -> JUMP; any other opcode -> FETCH with illegal_op=1 during this DECODE cycle.
REQ-019 MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEM_RD if the latched opcode is lw, MEM_WR if it is sw.
REQ-020 MEM_RD: i_or_d=1, mem_read=1; state is held until mem_ready=1, then next state is MEM_WB.
REQ-021 MEM_WR: i_or_d=1, mem_write=1; state is held until mem_ready=1, then next state is FETCH.
REQ-022 MEM_WB: mem_to_reg=1, reg_write=1, reg_dst=0; next state FETCH.
REQ-023 R_EX: alu_src_a=1, alu_src_b=00, alu_op=10; next state R_WB.
REQ-024 R_WB: reg_dst=1, reg_write=1; next state FETCH.
REQ-025 I_EX: alu_src_a=1, alu_src_b=10, alu_op=00; next state I_WB.
REQ-026 I_WB: reg_dst=0, reg_write=1; next state FETCH.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write_cond=1; next state FETCH.
REQ-028 JUMP: pc_src=10, pc_write=1; next state FETCH.
REQ-029 The opcode SHALL be latched into an internal register on the DECODE cycle; opcode changes in later states SHALL NOT affect the sequence.
REQ-030 Latency (mem_ready held high): lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2; each memory-wait state adds one cycle per mem_ready=0 cycle.
REQ-031 mem_read and mem_write SHALL never both be 1; reg_write SHALL never be 1 together with mem_read.

Reset
REQ-032 When rst_n=0, the state SHALL become IDLE immediately and asynchronously, the latched opcode SHALL become 0, and all outputs SHALL be 0 (mem_ready is ignored).
REQ-033 Reset asserted in any state, including mid-stall, SHALL abort the instruction with no further strobes; after deassertion, IDLE is followed by FETCH.

Structure
REQ-034 Package mips_mc_pkg SHALL hold the state enum, the opcode constants (R_TYPE, LW, SW, ADDI, BEQ, J) and the alu_src_b, pc_src and alu_op select encodings, shared with the datapath.
REQ-035 One sub-module, mc_out_decode, SHALL map state and mem_ready to the output vector combinationally; next-state logic and registers SHALL stay in mc_controller.

Verification
REQ-036 Reset release with opcode=100011 and mem_ready=1: IDLE, FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, then FETCH; reg_write=1 only in MEM_WB.
REQ-037 sw with mem_ready=0 for 3 cycles in MEM_WR: mem_write=1 for 4 cycles and i_or_d=1 throughout, then FETCH.
REQ-038 FETCH with mem_ready=0 for 2 cycles: ir_write=pc_write=0 while stalled; a single pulse of each on the ready cycle.
REQ-039 opcode=111111 at DECODE: illegal_op=1 for exactly 1 cycle, next state FETCH, no write strobes.
REQ-040 beq, then opcode changed to 000010 during BRANCH: pc_write_cond=1, pc_src=01, alu_op=01 for 1 cycle; pc_write remains 0.
REQ-041 rst_n pulled low during MEM_RD stall: all outputs 0 within the same cycle; IDLE then FETCH after release.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller and its datapath.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR,
        R_EX, R_WB, I_EX, I_WB, BRANCH, JUMP
    } state_t;

    localparam logic [5:0] R_TYPE = 6'b000000;
    localparam logic [5:0] LW     = 6'b100011;
    localparam logic [5:0] SW     = 6'b101011;
    localparam logic [5:0] ADDI   = 6'b001000;
    localparam logic [5:0] BEQ    = 6'b000100;
    localparam logic [5:0] J      = 6'b000010;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Moore control vector (illegal_op depends on the opcode, so it lives in the top)
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// State + mem_ready to control-strobe decode; purely combinational.
module mc_out_decode
    import mips_mc_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // Everything defaults low; each state raises only its own strobes
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_SHIMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_ADR, I_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            MEM_WR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            R_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            I_WB: begin
                ctrl.reg_write = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_src        = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
            end
            JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: state/opcode registers and next-state logic.
module mc_controller
    import mips_mc_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic           i_or_d,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     pc_src,
    output logic [1:0]     alu_op,
    output logic           illegal_op
);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q;
    ctrl_t          ctrl;

    // State register; reset lands in IDLE so every strobe drops at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Opcode captured in DECODE so later IR changes cannot steer MEM_ADR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 op_q <= '0;
        else if (state_q == DECODE) op_q <= opcode;
    end

    // Next-state selection and the DECODE-only illegal opcode flag
    always_comb begin
        state_d    = state_q;
        illegal_op = 1'b0;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (opcode == OPW'(LW) || opcode == OPW'(SW)) state_d = MEM_ADR;
                else if (opcode == OPW'(R_TYPE))              state_d = R_EX;
                else if (opcode == OPW'(ADDI))                state_d = I_EX;
                else if (opcode == OPW'(BEQ))                 state_d = BRANCH;
                else if (opcode == OPW'(J))                   state_d = JUMP;
                else begin
                    state_d    = FETCH;
                    illegal_op = 1'b1;
                end
            end
            MEM_ADR: state_d = (op_q == OPW'(SW)) ? MEM_WR : MEM_RD;
            MEM_RD:  if (mem_ready) state_d = MEM_WB;
            MEM_WR:  if (mem_ready) state_d = FETCH;
            MEM_WB:  state_d = FETCH;
            R_EX:    state_d = R_WB;
            R_WB:    state_d = FETCH;
            I_EX:    state_d = I_WB;
            I_WB:    state_d = FETCH;
            BRANCH:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    mc_out_decode u_dec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign pc_src        = ctrl.pc_src;
    assign alu_op        = ctrl.alu_op;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: expected strobe vectors queued per cycle.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_src, alu_op;

    int checks   = 0;
    int failures = 0;
    logic [16:0] exp_q[$];

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
    //  mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, alu_op, illegal_op}
    logic [16:0] outv;
    assign outv = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
                   alu_op, illegal_op};

    localparam logic [16:0] E_ZERO  = 17'b0;
    localparam logic [16:0] E_FETR  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_FETW  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_DEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_ILL   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1};
    localparam logic [16:0] E_ADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_MRD   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_MWR   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_MWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_REX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b10,1'b0};
    localparam logic [16:0] E_RWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_IWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_BR    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
    localparam logic [16:0] E_JMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0};

    mc_controller #(.OPW(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_src        (pc_src),
        .alu_op        (alu_op),
        .illegal_op    (illegal_op)
    );

    always #5 clk = ~clk;

    // Pop the oldest expectation and compare it with the sampled outputs
    task automatic check_now(input string tag);
        logic [16:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (outv === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, outv, e);
        end
    endtask

    // One clock: drive inputs, queue expectation, sample on negedge, advance
    task automatic step(input logic rdy, input logic [5:0] op,
                        input logic [16:0] exp, input string tag);
        mem_ready = rdy;
        opcode    = op;
        exp_q.push_back(exp);
        @(negedge clk);
        check_now(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b100011;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(E_ZERO);
        @(negedge clk);
        check_now("reset_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // lw, no stalls
        step(1, 6'b100011, E_ZERO, "lw_idle");
        step(1, 6'b100011, E_FETR, "lw_fetch");
        step(1, 6'b100011, E_DEC,  "lw_decode");
        step(1, 6'b100011, E_ADR,  "lw_memadr");
        step(1, 6'b100011, E_MRD,  "lw_memrd");
        step(1, 6'b100011, E_MWB,  "lw_memwb");
        step(1, 6'b101011, E_FETR, "sw_fetch");

        // sw with a 3-cycle write stall
        step(1, 6'b101011, E_DEC,  "sw_decode");
        step(1, 6'b101011, E_ADR,  "sw_memadr");
        step(0, 6'b101011, E_MWR,  "sw_stall1");
        step(0, 6'b101011, E_MWR,  "sw_stall2");
        step(0, 6'b101011, E_MWR,  "sw_stall3");
        step(1, 6'b101011, E_MWR,  "sw_done");

        // fetch stalled 2 cycles, then R-type
        step(0, 6'b000000, E_FETW, "fetch_stall1");
        step(0, 6'b000000, E_FETW, "fetch_stall2");
        step(1, 6'b000000, E_FETR, "fetch_ready");
        step(1, 6'b000000, E_DEC,  "r_decode");
        step(1, 6'b000000, E_REX,  "r_ex");
        step(1, 6'b000000, E_RWB,  "r_wb");

        // addi
        step(1, 6'b001000, E_FETR, "addi_fetch");
        step(1, 6'b001000, E_DEC,  "addi_decode");
        step(1, 6'b001000, E_ADR,  "addi_ex");
        step(1, 6'b001000, E_IWB,  "addi_wb");

        // beq with opcode flipped to j during BRANCH
        step(1, 6'b000100, E_FETR, "beq_fetch");
        step(1, 6'b000100, E_DEC,  "beq_decode");
        step(1, 6'b000010, E_BR,   "beq_branch");

        // j
        step(1, 6'b000010, E_FETR, "j_fetch");
        step(1, 6'b000010, E_DEC,  "j_decode");
        step(1, 6'b000010, E_JMP,  "j_jump");

        // illegal opcode
        step(1, 6'b111111, E_FETR, "ill_fetch");
        step(1, 6'b111111, E_ILL,  "ill_decode");

        // lw, opcode changed to sw after DECODE, then reset mid read stall
        step(1, 6'b100011, E_FETR, "lw2_fetch");
        step(1, 6'b100011, E_DEC,  "lw2_decode");
        step(1, 6'b101011, E_ADR,  "lw2_memadr");
        step(0, 6'b101011, E_MRD,  "lw2_latched_rd");
        step(0, 6'b101011, E_MRD,  "lw2_stall");
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        exp_q.push_back(E_ZERO);
        check_now("async_reset");
        @(posedge clk);
        #1;
        exp_q.push_back(E_ZERO);
        check_now("reset_held");
        rst_n = 1'b1;
        step(1, 6'b000000, E_ZERO, "post_rst_idle");
        step(1, 6'b000000, E_FETR, "post_rst_fetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
